// File: rtl/alu_arithmetic_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_arithmetic_if
// Description : Operand/opcode/result bundle for the registered arithmetic ALU.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_arithmetic_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             carry_in;
    logic [2:0]       opcode;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] left_over;
    logic             carry_out;

    modport master (
        output A, B, carry_in, opcode,
        input  result, left_over, carry_out
    );

    modport slave (
        input  A, B, carry_in, opcode,
        output result, left_over, carry_out
    );
endinterface
`default_nettype wire

// File: rtl/alu_arithmetic.sv
`default_nettype none
// ============================================================================
// Module      : alu_arithmetic
// Description : Unsigned add/sub/mul/div ALU with one-cycle registered outputs.
//               Division is built only when ALU_ARITHMETIC_DIV_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arithmetic #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_arithmetic_if.slave  bus
);

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_MUL = 3'b010;
`ifdef ALU_ARITHMETIC_DIV_EN
    localparam logic [2:0] c_OP_DIV = 3'b011;
`endif

    logic [WIDTH:0]       w_add_sum;
    logic [WIDTH:0]       w_sub_diff;
    logic [2*WIDTH-1:0]   w_product;
    logic [WIDTH-1:0]     w_result;
    logic [WIDTH-1:0]     w_left_over;
    logic                 w_carry_out;

    logic [WIDTH-1:0]     r_result;
    logic [WIDTH-1:0]     r_left_over;
    logic                 r_carry_out;

    assign w_add_sum  = {1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, bus.carry_in};
    // MSB of the extended difference is set exactly when A < B + carry_in.
    assign w_sub_diff = {1'b0, bus.A} - {1'b0, bus.B} - {{WIDTH{1'b0}}, bus.carry_in};
    assign w_product  = {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B};

`ifdef ALU_ARITHMETIC_DIV_EN
    logic [WIDTH-1:0] w_quotient;
    logic [WIDTH-1:0] w_remainder;
    logic [WIDTH:0]   w_partial;

    // Restoring divider; with B = 0 every trial succeeds, giving all-ones and A.
    always_comb begin
        w_quotient  = '0;
        w_remainder = '0;
        w_partial   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            w_partial = {w_remainder, bus.A[i]};
            if (w_partial >= {1'b0, bus.B}) begin
                w_partial     = w_partial - {1'b0, bus.B};
                w_quotient[i] = 1'b1;
            end
            w_remainder = w_partial[WIDTH-1:0];
        end
    end
`endif

    always_comb begin
        w_result    = '0;
        w_left_over = '0;
        w_carry_out = 1'b0;
        case (bus.opcode)
            c_OP_ADD: begin
                w_result    = w_add_sum[WIDTH-1:0];
                w_carry_out = w_add_sum[WIDTH];
            end
            c_OP_SUB: begin
                w_result    = w_sub_diff[WIDTH-1:0];
                w_carry_out = w_sub_diff[WIDTH];
            end
            c_OP_MUL: begin
                w_result    = w_product[WIDTH-1:0];
                w_left_over = w_product[2*WIDTH-1:WIDTH];
                w_carry_out = |w_product[2*WIDTH-1:WIDTH];
            end
`ifdef ALU_ARITHMETIC_DIV_EN
            c_OP_DIV: begin
                w_result    = w_quotient;
                w_left_over = w_remainder;
                w_carry_out = (bus.B == '0);
            end
`endif
            default: begin
                w_result    = '0;
                w_left_over = '0;
                w_carry_out = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result    <= '0;
            r_left_over <= '0;
            r_carry_out <= 1'b0;
        end else begin
            r_result    <= w_result;
            r_left_over <= w_left_over;
            r_carry_out <= w_carry_out;
        end
    end

    assign bus.result    = r_result;
    assign bus.left_over = r_left_over;
    assign bus.carry_out = r_carry_out;

endmodule
`default_nettype wire

// File: tb/tb_alu_arithmetic.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arithmetic
// Description : Self-checking bench for alu_arithmetic (WIDTH = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arithmetic;

    localparam int W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic cmp_en = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    typedef struct packed {
        logic [W-1:0] res;
        logic [W-1:0] lo;
        logic         co;
    } out_t;

    out_t exp_q;

    alu_arithmetic_if #(.WIDTH(W)) bus ();

    alu_arithmetic #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference behaviour written as plain integer arithmetic.
    function automatic out_t model(input int a, input int b, input int cin, input int op);
        out_t o;
        int   full;
        o    = '0;
        full = 0;
        case (op)
            0: begin
                full  = a + b + cin;
                o.res = full[W-1:0];
                o.co  = (full >= (1 << W));
            end
            1: begin
                full  = a - b - cin;
                o.res = full[W-1:0];
                o.co  = (a < b + cin);
            end
            2: begin
                full  = a * b;
                o.res = full[W-1:0];
                o.lo  = W'(full >> W);
                o.co  = ((full >> W) != 0);
            end
`ifdef ALU_ARITHMETIC_DIV_EN
            3: begin
                if (b == 0) begin
                    o.res = '1;
                    o.lo  = W'(a);
                    o.co  = 1'b1;
                end else begin
                    o.res = W'(a / b);
                    o.lo  = W'(a % b);
                end
            end
`endif
            default: o = '0;
        endcase
        return o;
    endfunction

    function automatic out_t dut_out();
        return {bus.result, bus.left_over, bus.carry_out};
    endfunction

    task automatic check(input string name, input out_t act, input out_t want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got result=%b left_over=%b carry_out=%b, expected result=%b left_over=%b carry_out=%b",
                     name, act.res, act.lo, act.co, want.res, want.lo, want.co);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            exp_q <= '0;
        else
            exp_q <= model(int'(bus.A), int'(bus.B), int'(bus.carry_in), int'(bus.opcode));
    end

    always @(negedge clk) begin
        if (cmp_en)
            check("model", dut_out(), exp_q);
    end

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic [2:0] op);
        bus.A        = a;
        bus.B        = b;
        bus.carry_in = cin;
        bus.opcode   = op;
    endtask

    // Drive at a falling edge, then check the registered outputs one cycle on.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic [2:0] op, input string name,
                         input logic [W-1:0] r, input logic [W-1:0] l, input logic c);
        drive(a, b, cin, op);
        @(negedge clk);
        check(name, dut_out(), {r, l, c});
    endtask

    initial begin
        int vals [5];
        vals = '{0, 1, 7, 8, 15};
        drive('0, '0, 1'b0, 3'b000);
        repeat (2) @(negedge clk);
        check("reset_state", dut_out(), '0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        do_op(4'b1010, 4'b0101, 1'b0, 3'b000, "add",        4'b1111, 4'b0000, 1'b0);
        do_op(4'b1010, 4'b0101, 1'b0, 3'b001, "sub",        4'b0101, 4'b0000, 1'b0);
        do_op(4'b0011, 4'b0101, 1'b0, 3'b001, "sub_borrow", 4'b1110, 4'b0000, 1'b1);
        do_op(4'b1010, 4'b0101, 1'b0, 3'b010, "mul",        4'b0010, 4'b0011, 1'b1);
`ifdef ALU_ARITHMETIC_DIV_EN
        do_op(4'b1010, 4'b0101, 1'b0, 3'b011, "div",        4'b0010, 4'b0000, 1'b0);
        do_op(4'b1010, 4'b0000, 1'b0, 3'b011, "div_zero",   4'b1111, 4'b1010, 1'b1);
        do_op(4'b1111, 4'b0100, 1'b1, 3'b011, "div_rem",    4'b0011, 4'b0011, 1'b0);
`else
        do_op(4'b1010, 4'b0101, 1'b0, 3'b011, "div_off",    4'b0000, 4'b0000, 1'b0);
        do_op(4'b1010, 4'b0000, 1'b0, 3'b011, "div_off_b0", 4'b0000, 4'b0000, 1'b0);
`endif
        do_op(4'b1010, 4'b0101, 1'b1, 3'b000, "add_cin",    4'b0000, 4'b0000, 1'b1);
        do_op(4'b1010, 4'b0101, 1'b1, 3'b111, "reserved7",  4'b0000, 4'b0000, 1'b0);
        do_op(4'b1111, 4'b1111, 1'b1, 3'b100, "reserved4",  4'b0000, 4'b0000, 1'b0);
        do_op(4'b0011, 4'b0101, 1'b1, 3'b010, "mul_cin",    4'b1111, 4'b0000, 1'b0);
        do_op(4'b1111, 4'b1111, 1'b0, 3'b010, "mul_max",    4'b0001, 4'b1110, 1'b1);
        do_op(4'b1111, 4'b1111, 1'b1, 3'b000, "add_max",    4'b1111, 4'b0000, 1'b1);
        do_op(4'b0000, 4'b1111, 1'b1, 3'b001, "sub_min",    4'b0000, 4'b0000, 1'b1);
        do_op(4'b0101, 4'b0100, 1'b1, 3'b001, "sub_equal",  4'b0000, 4'b0000, 1'b0);

        // Back-to-back sweep; the model compare checks every cycle.
        for (int op = 0; op < 8; op++)
            for (int ia = 0; ia < 5; ia++)
                for (int ib = 0; ib < 5; ib++) begin
                    drive(W'(vals[ia]), W'(vals[ib]), 1'((ia + ib + op) % 2), 3'(op));
                    @(negedge clk);
                end

        // Asynchronous reset between edges with non-zero outputs.
        do_op(4'b1111, 4'b1111, 1'b0, 3'b010, "pre_reset", 4'b0001, 4'b1110, 1'b1);
        drive(4'b0001, 4'b0001, 1'b0, 3'b000);
        #2 rst_n = 1'b0;
        #1 check("async_reset", dut_out(), '0);
        @(negedge clk);
        check("held_reset", dut_out(), '0);
        rst_n = 1'b1;
        do_op(4'b0001, 4'b0001, 1'b0, 3'b000, "first_after_reset", 4'b0010, 4'b0000, 1'b0);
        do_op(4'b0110, 4'b0011, 1'b0, 3'b001, "second_after_reset", 4'b0011, 4'b0000, 1'b0);

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/alu_arithmetic.md
ALU_ARITHMETIC -- requirements
Module: alu_arithmetic

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter WIDTH, default 4, operand/result width; the block SHALL support WIDTH 2..16.
REQ-003 clk  input  1  rising-edge clock; sole clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 A  input  WIDTH  operand A, unsigned.
REQ-006 B  input  WIDTH  operand B, unsigned.
REQ-007 carry_in  input  1  carry (add) / borrow (sub) input; ignored for mul/div.
REQ-008 opcode  input  3  000 add, 001 sub, 010 mul, 011 div, 100-111 reserved.
REQ-009 result  output  WIDTH  sum/difference, product low half, or quotient.
REQ-010 left_over  output  WIDTH  product high half or remainder; zero for add/sub.
REQ-011 carry_out  output  1  carry, borrow, overflow or error flag per opcode.

Function
REQ-012 Inputs SHALL be sampled on every rising clk edge; outputs SHALL be registered and update exactly 1 cycle after sampling; no handshake, new operation every cycle.
REQ-013 Add: {carry_out,result} = A + B + carry_in (WIDTH+1 bits); left_over = 0.
REQ-014 Sub: result = (A - B - carry_in) mod 2^WIDTH; carry_out = 1 iff A < B + carry_in (borrow); left_over = 0.
REQ-015 Mul: full 2*WIDTH-bit unsigned product; result = low WIDTH bits, left_over = high WIDTH bits; carry_out = 1 iff left_over != 0.
REQ-016 Div: result = A / B, left_over = A % B (unsigned, truncating); carry_out = 0.
REQ-017 Div with B = 0: result = all ones, left_over = A, carry_out = 1 (error flag).
REQ-018 Reserved opcodes: result, left_over, carry_out SHALL all be 0.
REQ-019 All arithmetic SHALL be unsigned; no sign extension or saturation.
REQ-020 Changing opcode or operands mid-stream SHALL only affect the output of the following cycle; no state carries between operations.

Reset
REQ-021 While rst_n = 0, result, left_over and carry_out SHALL be 0 immediately (asynchronous assertion).
REQ-022 Reset deassertion SHALL be synchronized to clk; the first sample SHALL occur on the first rising edge with rst_n = 1, output valid one cycle later.
REQ-023 Reset asserted mid-operation SHALL discard the in-flight operation.

Configuration
REQ-024 Macro ALU_ARITHMETIC_DIV_EN: when defined, opcode 011 SHALL perform division per REQ-016/017.
REQ-025 When ALU_ARITHMETIC_DIV_EN is undefined, no divider logic SHALL be synthesized and opcode 011 SHALL behave as a reserved opcode (all outputs 0).

Verification
REQ-026 A=1010, B=0101, cin=0, op=000 -> result 1111, left_over 0000, carry_out 0.
REQ-027 Same operands, op=001 -> result 0101, left_over 0000, carry_out 0; A=0011, B=0101, op=001 -> result 1110, carry_out 1.
REQ-028 Same operands, op=010 -> result 0010, left_over 0011, carry_out 1.
REQ-029 Same operands, op=011 (DIV_EN defined) -> result 0010, left_over 0000, carry_out 0; B=0000 -> result 1111, left_over 1010, carry_out 1; DIV_EN undefined -> all 0.
REQ-030 A=1010, B=0101, cin=1, op=000 -> result 0000, left_over 0000, carry_out 1; op=111 -> all outputs 0.
REQ-031 Assert rst_n=0 between clock edges while outputs nonzero -> all outputs 0 without a clock edge; each result appears exactly one cycle after its inputs are sampled.
